// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK modulator path.
//   state_e          : frame sequencer states (IDLE=0, PRE=1, DATA=2, GUARD=3)
//   SAMPLE_*_DEF     : default carrier geometry shared with the sine generator
//   sym_cnt_width()  : width of the symbol counter for given preamble/guard lengths
package bpsk_pkg;

  localparam int unsigned SAMPLE_NUMBER_DEF = 256;
  localparam int unsigned SAMPLE_WIDTH_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_DATA  = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  function automatic int unsigned sym_cnt_width(input int unsigned pre_len,
                                                input int unsigned guard_len);
    int unsigned m;
    m = (pre_len > guard_len) ? pre_len : guard_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bpsk_sym_timer.sv
// Symbol timer: sample counter (0..SAMPLE_NUMBER-1, wrapping) plus a symbol
// counter that advances once per completed symbol.
//   clk, rst      : clock, synchronous active-high reset
//   clr           : clear both counters (priority over en)
//   en            : advance the sample counter
//   sym_en        : allow the symbol counter to advance at a boundary
//   sym_last_val  : symbol index that flags sym_last
//   samp_cnt      : current sample index within the symbol
//   sym_odd       : LSB of the symbol counter
//   boundary      : last sample of the current symbol
//   sym_last      : symbol counter equals sym_last_val
module bpsk_sym_timer
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_NUMBER = SAMPLE_NUMBER_DEF,
  parameter int unsigned SYM_W         = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             en,
  input  logic                             sym_en,
  input  logic [SYM_W-1:0]                 sym_last_val,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] samp_cnt,
  output logic                             sym_odd,
  output logic                             boundary,
  output logic                             sym_last
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_NUMBER);
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMPLE_NUMBER - 1);

  logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;

  assign boundary = (samp_cnt_q == SAMP_LAST);
  assign sym_last = (sym_cnt_q == sym_last_val);
  assign sym_odd  = sym_cnt_q[0];
  assign samp_cnt = samp_cnt_q;

  always_comb begin
    samp_cnt_d = samp_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    if (clr) begin
      samp_cnt_d = '0;
      sym_cnt_d  = '0;
    end else if (en) begin
      samp_cnt_d = boundary ? '0 : samp_cnt_q + CNT_W'(1);
      if (sym_en && boundary) begin
        sym_cnt_d = sym_cnt_q + SYM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q <= '0;
      sym_cnt_q  <= '0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
    end
  end

endmodule

// File: rtl/bpsk_mod_ctrl.sv
// BPSK frame sequencer. Gates the shared sine generator for whole carrier
// periods: alternating preamble, one symbol per input bit, silent guard.
//   clk, rst            : clock, synchronous active-high reset
//   s_data/s_last/      : bit stream in (1 -> sin, 0 -> neg_sin), frame end
//   s_valid/s_ready       marker and handshake
//   gen_en              : generator enable
//   gen_cnt             : generator phase counter, cross-checked against samp_cnt
//   sin_in/neg_sin_in   : generator samples (1-cycle ROM latency)
//   mod_out/mod_valid   : modulated sample stream
//   busy                : sequencer not idle
//   underrun            : pulse when no bit is available at a symbol boundary
//   phase_err           : sticky generator misalignment flag
//   frame_done          : pulse on the last guard cycle
module bpsk_mod_ctrl
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_NUMBER = SAMPLE_NUMBER_DEF,
  parameter int unsigned SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
  parameter int unsigned PREAMBLE_LEN  = 8,
  parameter int unsigned GUARD_LEN     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_data,
  input  logic                             s_last,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             gen_en,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] gen_cnt,
  input  logic [SAMPLE_WIDTH-1:0]          sin_in,
  input  logic [SAMPLE_WIDTH-1:0]          neg_sin_in,
  output logic [SAMPLE_WIDTH-1:0]          mod_out,
  output logic                             mod_valid,
  output logic                             busy,
  output logic                             underrun,
  output logic                             phase_err,
  output logic                             frame_done
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_NUMBER);
  localparam int unsigned SYM_W = sym_cnt_width(PREAMBLE_LEN, GUARD_LEN);
  localparam logic [SYM_W-1:0] PRE_LAST   = SYM_W'(PREAMBLE_LEN - 1);
  localparam logic [SYM_W-1:0] GUARD_LAST = SYM_W'(GUARD_LEN - 1);

  state_e state_q, state_d;
  logic   cur_bit_q, cur_bit_d;
  logic   cur_last_q, cur_last_d;
  logic   en_dly_q, en_dly_d;
  logic   bit_dly_q, bit_dly_d;
  logic   mod_valid_q, mod_valid_d;
  logic   phase_err_q, phase_err_d;
  logic [SAMPLE_WIDTH-1:0] mod_out_q, mod_out_d;

  logic             tmr_clr, tmr_en, tmr_sym_en;
  logic [SYM_W-1:0] sym_last_val;
  logic [CNT_W-1:0] samp_cnt;
  logic             sym_odd, boundary, sym_last;
  logic             sym_bit;

  assign sym_last_val = (state_q == ST_GUARD) ? GUARD_LAST : PRE_LAST;

  bpsk_sym_timer #(
    .SAMPLE_NUMBER(SAMPLE_NUMBER),
    .SYM_W        (SYM_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (tmr_clr),
    .en          (tmr_en),
    .sym_en      (tmr_sym_en),
    .sym_last_val(sym_last_val),
    .samp_cnt    (samp_cnt),
    .sym_odd     (sym_odd),
    .boundary    (boundary),
    .sym_last    (sym_last)
  );

  // Counters restart on every state change; in DATA the clear at a boundary
  // coincides with the natural sample-counter wrap.
  always_comb begin
    state_d    = state_q;
    cur_bit_d  = cur_bit_q;
    cur_last_d = cur_last_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    tmr_sym_en = 1'b0;
    s_ready    = 1'b0;
    underrun   = 1'b0;
    frame_done = 1'b0;
    gen_en     = 1'b0;
    sym_bit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (s_valid) state_d = ST_PRE;
      end
      ST_PRE: begin
        gen_en     = 1'b1;
        sym_bit    = ~sym_odd;
        tmr_en     = 1'b1;
        tmr_sym_en = 1'b1;
        if (boundary && sym_last) begin
          s_ready = 1'b1;
          tmr_clr = 1'b1;
          if (s_valid) begin
            cur_bit_d  = s_data;
            cur_last_d = s_last;
            state_d    = ST_DATA;
          end else begin
            underrun = 1'b1;
            state_d  = ST_GUARD;
          end
        end
      end
      ST_DATA: begin
        gen_en  = 1'b1;
        sym_bit = cur_bit_q;
        tmr_en  = 1'b1;
        if (boundary) begin
          tmr_clr = 1'b1;
          if (cur_last_q) begin
            state_d = ST_GUARD;
          end else begin
            s_ready = 1'b1;
            if (s_valid) begin
              cur_bit_d  = s_data;
              cur_last_d = s_last;
            end else begin
              underrun = 1'b1;
              state_d  = ST_GUARD;
            end
          end
        end
      end
      ST_GUARD: begin
        tmr_en     = 1'b1;
        tmr_sym_en = 1'b1;
        if (boundary && sym_last) begin
          frame_done = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output pipe: one stage to match the generator's ROM latency, one for mod_out.
  always_comb begin
    en_dly_d    = gen_en;
    bit_dly_d   = sym_bit;
    mod_valid_d = en_dly_q;
    mod_out_d   = en_dly_q ? (bit_dly_q ? sin_in : neg_sin_in) : '0;
    phase_err_d = phase_err_q | (gen_en & (gen_cnt != samp_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_bit_q   <= 1'b0;
      cur_last_q  <= 1'b0;
      en_dly_q    <= 1'b0;
      bit_dly_q   <= 1'b0;
      mod_valid_q <= 1'b0;
      mod_out_q   <= '0;
      phase_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_bit_q   <= cur_bit_d;
      cur_last_q  <= cur_last_d;
      en_dly_q    <= en_dly_d;
      bit_dly_q   <= bit_dly_d;
      mod_valid_q <= mod_valid_d;
      mod_out_q   <= mod_out_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign mod_out   = mod_out_q;
  assign mod_valid = mod_valid_q;
  assign phase_err = phase_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bpsk_mod_ctrl.sv
module tb_bpsk_mod_ctrl;

  localparam int unsigned TB_SN = 8;
  localparam int unsigned TB_P  = 2;
  localparam int unsigned TB_G  = 2;
  localparam int unsigned TB_W  = 12;

  logic            clk;
  logic            rst;
  logic            s_data, s_last, s_valid, s_ready;
  logic            gen_en;
  logic [2:0]      gen_cnt;
  logic [TB_W-1:0] sin_in, neg_sin_in, mod_out;
  logic            mod_valid, busy, underrun, phase_err, frame_done;

  // Sine generator model: counter advances while enabled, ROM output registered.
  logic [2:0]      gcnt_q;
  logic [2:0]      gen_off;
  logic            gen_arstn;

  function automatic logic [TB_W-1:0] sin_rom(input logic [2:0] i);
    return 12'h100 + {9'd0, i};
  endfunction
  function automatic logic [TB_W-1:0] neg_rom(input logic [2:0] i);
    return 12'h800 + {9'd0, i};
  endfunction

  assign gen_arstn = ~rst;
  assign gen_cnt   = gcnt_q + gen_off;

  always_ff @(posedge clk or negedge gen_arstn) begin
    if (!gen_arstn) begin
      gcnt_q     <= '0;
      sin_in     <= '0;
      neg_sin_in <= '0;
    end else begin
      if (gen_en) gcnt_q <= gcnt_q + 3'd1;
      sin_in     <= sin_rom(gcnt_q);
      neg_sin_in <= neg_rom(gcnt_q);
    end
  end

  bpsk_mod_ctrl #(
    .SAMPLE_NUMBER(TB_SN),
    .SAMPLE_WIDTH (TB_W),
    .PREAMBLE_LEN (TB_P),
    .GUARD_LEN    (TB_G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .gen_en    (gen_en),
    .gen_cnt   (gen_cnt),
    .sin_in    (sin_in),
    .neg_sin_in(neg_sin_in),
    .mod_out   (mod_out),
    .mod_valid (mod_valid),
    .busy      (busy),
    .underrun  (underrun),
    .phase_err (phase_err),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [TB_W-1:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_sym(input logic b);
    for (int k = 0; k < int'(TB_SN); k++)
      sb_q.push_back(b ? sin_rom(3'(k)) : neg_rom(3'(k)));
  endtask

  typedef struct {
    logic [7:0]  bits;      // frame bits, LSB sent first
    int unsigned nbits;
    int unsigned avail;     // bits the source offers before going quiet
    bit          keep;      // hold s_valid high after the frame's bits
    int unsigned exp_ready;
    int unsigned exp_valid;
    int unsigned exp_ur;
    int unsigned exp_done;  // cycle of frame_done, counted from the IDLE start cycle
  } vec_t;

  vec_t vecs[5];

  // Cycle 0 is the IDLE cycle in which s_valid is first presented.
  task automatic run_frame(input vec_t v);
    int unsigned idx = 0, cyc = 0;
    int unsigned n_ready = 0, n_valid = 0, n_ur = 0;
    int unsigned first_ready = 0, first_valid = 0, last_valid = 0, ur_cyc = 0, done_cyc = 0;
    bit done = 1'b0;
    logic [TB_W-1:0] exp_s;
    while (!done && cyc < 200) begin
      @(negedge clk);
      s_valid = (cyc == 0) || (idx < v.avail && idx < v.nbits) || (idx >= v.nbits && v.keep);
      s_data  = (idx < v.nbits) ? v.bits[idx] : 1'b1;
      s_last  = (idx < v.nbits) && (idx == v.nbits - 1);
      #1;
      if (cyc == 0) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gen_en", 32'(gen_en), 32'd0);
        for (int p = 0; p < int'(TB_P); p++) push_sym((p % 2) == 0);
      end
      if (cyc == 1) begin
        chk("pre_gen_en", 32'(gen_en), 32'd1);
        chk("pre_gen_cnt", 32'(gen_cnt), 32'd0);
        chk("pre_busy", 32'(busy), 32'd1);
      end
      if (s_ready) begin
        n_ready++;
        if (n_ready == 1) first_ready = cyc;
        if (s_valid) begin
          push_sym(s_data);
          idx++;
        end
      end
      if (underrun) begin
        n_ur++;
        ur_cyc = cyc;
      end
      if (mod_valid) begin
        n_valid++;
        if (n_valid == 1) first_valid = cyc;
        last_valid = cyc;
        if (sb_q.size() == 0) begin
          chk("sb_empty_on_valid", 32'(mod_out), 32'hFFFF_FFFF);
        end else begin
          exp_s = sb_q.pop_front();
          chk("mod_out", 32'(mod_out), 32'(exp_s));
        end
      end
      if (frame_done) begin
        done     = 1'b1;
        done_cyc = cyc;
      end
      cyc++;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL frame_timeout: no frame_done after %0d cycles, required by %0d", cyc, v.exp_done);
    end
    chk("ready_count", 32'(n_ready), 32'(v.exp_ready));
    chk("first_ready", 32'(first_ready), 32'(TB_P * TB_SN));
    chk("valid_count", 32'(n_valid), 32'(v.exp_valid));
    chk("first_valid", 32'(first_valid), 32'd3);
    chk("valid_span", 32'(last_valid - first_valid + 1), 32'(n_valid));
    chk("underrun_count", 32'(n_ur), 32'(v.exp_ur));
    if (v.exp_ur != 0) chk("underrun_tail", 32'(last_valid), 32'(ur_cyc + 2));
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    chk("frame_phase_err", 32'(phase_err), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{bits: 8'b0000_0101, nbits: 3, avail: 3, keep: 1'b0,
                exp_ready: 3, exp_valid: 40, exp_ur: 0, exp_done: 56};
    vecs[1] = '{bits: 8'b0000_0010, nbits: 2, avail: 2, keep: 1'b1,
                exp_ready: 2, exp_valid: 32, exp_ur: 0, exp_done: 48};
    vecs[2] = '{bits: 8'b0000_0011, nbits: 4, avail: 2, keep: 1'b0,
                exp_ready: 3, exp_valid: 32, exp_ur: 1, exp_done: 48};
    vecs[3] = '{bits: 8'b0000_0000, nbits: 1, avail: 1, keep: 1'b0,
                exp_ready: 1, exp_valid: 24, exp_ur: 0, exp_done: 40};
    vecs[4] = '{bits: 8'b0000_0001, nbits: 1, avail: 0, keep: 1'b0,
                exp_ready: 1, exp_valid: 16, exp_ur: 1, exp_done: 32};

    rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0; gen_off = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gen_en", 32'(gen_en), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mod_valid", 32'(mod_valid), 32'd0);
    chk("rst_mod_out", 32'(mod_out), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_phase_err", 32'(phase_err), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Phase error mid-DATA, then reset mid-frame.
    tick();
    s_valid = 1'b1; s_data = 1'b1; s_last = 1'b0;
    repeat (22) tick();
    chk("pe_before", 32'(phase_err), 32'd0);
    chk("pe_mid_valid", 32'(mod_valid), 32'd1);
    gen_off = 3'd1;
    tick();
    chk("pe_set", 32'(phase_err), 32'd1);
    gen_off = 3'd0;
    repeat (5) tick();
    chk("pe_sticky", 32'(phase_err), 32'd1);
    rst = 1'b1; s_valid = 1'b0;
    tick();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_gen_en", 32'(gen_en), 32'd0);
    chk("mrst_s_ready", 32'(s_ready), 32'd0);
    chk("mrst_mod_valid", 32'(mod_valid), 32'd0);
    chk("mrst_mod_out", 32'(mod_out), 32'd0);
    chk("mrst_underrun", 32'(underrun), 32'd0);
    chk("mrst_phase_err", 32'(phase_err), 32'd0);
    chk("mrst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    run_frame(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
